// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory controller
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p0_r_en,
    input  logic                  p0_w_en,
    input  logic                  p1_r_en,
    input  logic                  p1_w_en,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic                  p0_cplt,
    output logic                  p1_cplt,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    input  logic                  mem_rdy,
    input  logic                  mem_cplt,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       own_q, own_d;
    logic                       ptr_q, ptr_d;
    logic                       rd_q, rd_d;
    logic                       err_q, err_d;
    logic                       r_en_q, r_en_d;
    logic                       w_en_q, w_en_d;
    logic [1:0]                 gnt_q, gnt_d;
    logic [1:0]                 cplt_q, cplt_d;
    logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       req0, req1, sel;

    assign req0 = p0_r_en | p0_w_en;
    assign req1 = p1_r_en | p1_w_en;
    assign sel  = (req0 & req1) ? ptr_q : req1;

    // next-state and registered-output computation; ptr_q names the port favoured on contention
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        rd_d    = rd_q;
        err_d   = err_q;
        r_en_d  = r_en_q;
        w_en_d  = w_en_q;
        gnt_d   = gnt_q;
        cplt_d  = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                own_d   = sel;
                rd_d    = sel ? p1_r_en : p0_r_en;
                addr_d  = sel ? p1_addr : p0_addr;
                wdata_d = sel ? p1_wdata : p0_wdata;
                gnt_d   = sel ? 2'b10 : 2'b01;
                r_en_d  = rd_d;
                w_en_d  = ~rd_d;
                state_d = ISSUE;
            end
            ISSUE: if (mem_rdy) begin
                r_en_d  = 1'b0;
                w_en_d  = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (mem_cplt || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                rdata_d[own_q] = mem_cplt ? (rd_q ? mem_data_out : '0) : '1;
                err_d          = err_q | ~mem_cplt;
                cplt_d[own_q]  = 1'b1;
                state_d        = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = ~own_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset aborts any transaction and drops strobes at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            ptr_q   <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
            gnt_q   <= '0;
            cplt_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            r_en_q  <= r_en_d;
            w_en_q  <= w_en_d;
            gnt_q   <= gnt_d;
            cplt_q  <= cplt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign p0_gnt      = gnt_q[0];
    assign p1_gnt      = gnt_q[1];
    assign p0_cplt     = cplt_q[0];
    assign p1_cplt     = cplt_q[1];
    assign p0_rdata    = rdata_q[0];
    assign p1_rdata    = rdata_q[1];
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_r_en    = r_en_q;
    assign mem_w_en    = w_en_q;
    assign err         = err_q;
endmodule
